pipelined_alu: RTL and testbench

Parametrised, handshaked successor to the team's 16-bit combinational ALU. It accepts one operation at a time over a valid/ready input channel and registers result plus C/V/N/Z flags into an output register drained by a valid/ready output channel. It adds an iterative shift-add multiplier driven by a small FSM. It sits between the operand-fetch stage and the writeback stage of the datapath.

---
 rtl/pipelined_alu.sv | 184 ++++++++++++++++++
 tb/tb_pipelined_alu.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu.sv
// Handshaked ALU with registered result/flags; define ALU_MUL_EN to add the
// iterative shift-add multiplier (opcode 110), otherwise 110 acts as reserved.
module pipelined_alu #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] inputA,
    input  logic [WIDTH-1:0] inputB,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_flag,
    output logic             overflow_flag,
    output logic             negative_flag,
    output logic             zero_flag
);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOr  = 3'b011;
    localparam logic [2:0] OpXor = 3'b100;
    localparam logic [2:0] OpNot = 3'b101;
`ifdef ALU_MUL_EN
    localparam logic [2:0] OpMul = 3'b110;
    localparam int unsigned CntW = $clog2(WIDTH) + 1;
`endif

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q, overflow_q, negative_q, zero_q;

    logic             out_free;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_res;
    logic             load_c, load_v, load_n;

    logic [WIDTH:0]   add_sum, sub_sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_n;

    assign out_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign add_sum = {1'b0, inputA} + {1'b0, inputB};
    assign sub_sum = {1'b0, inputA} + {1'b0, ~inputB} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_n   = 1'b0;
        case (opcode)
            OpAdd: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (inputA[WIDTH-1] == inputB[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != inputA[WIDTH-1]);
                alu_n   = add_sum[WIDTH-1];
            end
            OpSub: begin
                alu_res = sub_sum[WIDTH-1:0];
                // Carry flag reports borrow, so it is the inverted adder carry.
                alu_c   = !sub_sum[WIDTH];
                alu_v   = (inputA[WIDTH-1] != inputB[WIDTH-1]) &&
                          (sub_sum[WIDTH-1] != inputA[WIDTH-1]);
                alu_n   = sub_sum[WIDTH-1];
            end
            OpAnd:   alu_res = inputA & inputB;
            OpOr:    alu_res = inputA | inputB;
            OpXor:   alu_res = inputA ^ inputB;
            OpNot:   alu_res = ~inputA;
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN
    typedef enum logic {StIdle, StBusy} state_e;

    state_e             state_q;
    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_next;
    logic [WIDTH-1:0]   mplier_q;
    logic [CntW-1:0]    cnt_q;
    logic               last_iter;
    logic               mul_done;

    assign acc_next  = mplier_q[0] ? acc_q + mcand_q : acc_q;
    assign last_iter = (cnt_q == CntW'(WIDTH - 1));
    // Final iteration waits for a free output register rather than dropping the product.
    assign mul_done  = (state_q == StBusy) && last_iter && out_free;
    assign in_ready  = rst_n && (state_q == StIdle) && out_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept && opcode == OpMul) begin
                        state_q  <= StBusy;
                        mcand_q  <= {{WIDTH{1'b0}}, inputA};
                        mplier_q <= inputB;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                    end
                end
                StBusy: begin
                    if (!last_iter || out_free) begin
                        acc_q    <= acc_next;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q + CntW'(1);
                        if (last_iter) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        load     = mul_done || (accept && opcode != OpMul);
        load_res = alu_res;
        load_c   = alu_c;
        load_v   = alu_v;
        load_n   = alu_n;
        if (mul_done) begin
            load_res = acc_next[WIDTH-1:0];
            load_c   = |acc_next[2*WIDTH-1:WIDTH];
            load_v   = 1'b0;
            load_n   = acc_next[WIDTH-1];
        end
    end
`else
    assign in_ready = rst_n && out_free;

    always_comb begin
        load     = accept;
        load_res = alu_res;
        load_c   = alu_c;
        load_v   = alu_v;
        load_n   = alu_n;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            negative_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            result_q    <= load_res;
            carry_q     <= load_c;
            overflow_q  <= load_v;
            negative_q  <= load_n;
            zero_q      <= (load_res == '0);
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid     = out_valid_q;
    assign result        = result_q;
    assign carry_flag    = carry_q;
    assign overflow_flag = overflow_q;
    assign negative_flag = negative_q;
    assign zero_flag     = zero_q;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu; MUL checks compile in when ALU_MUL_EN is defined.
module tb_pipelined_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [2:0]  op = '0;

    wire         in_ready, out_valid;
    wire  [15:0] result;
    wire         c, v, n, z;

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_alu #(.WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .inputA        (a),
        .inputB        (b),
        .opcode        (op),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .result        (result),
        .carry_flag    (c),
        .overflow_flag (v),
        .negative_flag (n),
        .zero_flag     (z)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        in_valid = 1'b1;
        op       = o;
        a        = x;
        b        = y;
    endtask

    initial begin
        // Reset
        step();
        check("rst in_ready", in_ready, 0);
        step();
        check("rst out_valid", out_valid, 0);
        check("rst result", result, 0);
        check("rst flags", {c, v, n, z}, 4'b0000);
        rst_n = 1'b1;
        #1;
        check("post-rst in_ready", in_ready, 1);

        // Test 1: ADD with signed overflow ({C,V,N,Z})
        issue(3'b000, 16'h7FFF, 16'h0001);
        check("add pre out_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        check("add out_valid", out_valid, 1);
        check("add result", result, 16'h8000);
        check("add flags", {c, v, n, z}, 4'b0110);
        step();
        check("add delivered", out_valid, 0);

        // Test 2: SUB borrow then SUB overflow, back to back
        issue(3'b001, 16'h0003, 16'h0005);
        step();
        check("sub1 result", result, 16'hFFFE);
        check("sub1 flags", {c, v, n, z}, 4'b1010);
        issue(3'b001, 16'h8000, 16'h0001);
        check("sub2 in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("sub2 out_valid", out_valid, 1);
        check("sub2 result", result, 16'h7FFF);
        check("sub2 flags", {c, v, n, z}, 4'b0100);

        // Test 3: XOR to zero then NOT on the next cycle
        issue(3'b100, 16'hA5A5, 16'hA5A5);
        step();
        check("xor result", result, 16'h0000);
        check("xor flags", {c, v, n, z}, 4'b0001);
        issue(3'b101, 16'h00FF, 16'h1234);
        step();
        in_valid = 1'b0;
        check("not out_valid", out_valid, 1);
        check("not result", result, 16'hFF00);
        check("not flags", {c, v, n, z}, 4'b0000);
        issue(3'b011, 16'h0F00, 16'h00F0);
        step();
        in_valid = 1'b0;
        check("or result", result, 16'h0FF0);
        step();
        check("idle out_valid", out_valid, 0);

        // Test 5: backpressure holds the ADD result, AND waits
        out_ready = 1'b0;
        issue(3'b000, 16'h0001, 16'h0001);
        step();
        issue(3'b010, 16'hF0F0, 16'h0FF0);
        for (int i = 0; i < 3; i++) begin
            check("bp in_ready", in_ready, 0);
            step();
            check("bp out_valid", out_valid, 1);
            check("bp result", result, 16'h0002);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("and out_valid", out_valid, 1);
        check("and result", result, 16'h00F0);
        check("and flags", {c, v, n, z}, 4'b0000);
        step();
        check("and delivered", out_valid, 0);

`ifdef ALU_MUL_EN
        // Test 4: iterative MUL, operand changes during BUSY ignored
        issue(3'b110, 16'h0100, 16'h0100);
        step();
        in_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i < 16) begin
                check("mul busy out_valid", out_valid, 0);
                check("mul busy in_ready", in_ready, 0);
            end
            a = 16'($urandom);
            b = 16'($urandom);
            step();
        end
        check("mul1 out_valid", out_valid, 1);
        check("mul1 result", result, 16'h0000);
        check("mul1 flags", {c, v, n, z}, 4'b1001);
        check("mul1 in_ready", in_ready, 1);
        issue(3'b110, 16'h00FF, 16'h0003);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
        end
        check("mul2 result", result, 16'h02FD);
        check("mul2 flags", {c, v, n, z}, 4'b0000);
        step();

        // Test 6: reset at the 5th BUSY cycle
        issue(3'b110, 16'h1234, 16'h0FFF);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
        end
        rst_n = 1'b0;
        step();
`else
        // Test 4: opcode 110 is reserved without the multiplier
        issue(3'b110, 16'h1234, 16'h5678);
        step();
        in_valid = 1'b0;
        check("rsv out_valid", out_valid, 1);
        check("rsv result", result, 16'h0000);
        check("rsv flags", {c, v, n, z}, 4'b0001);
        step();
        check("rsv delivered", out_valid, 0);

        // Test 6: reset while a result is held under backpressure
        out_ready = 1'b0;
        issue(3'b000, 16'h8000, 16'h8001);
        step();
        in_valid = 1'b0;
        check("pre-rst held", result, 16'h0001);
        rst_n = 1'b0;
        step();
        out_ready = 1'b1;
`endif
        check("abort in_ready", in_ready, 0);
        check("abort out_valid", out_valid, 0);
        check("abort result", result, 0);
        check("abort flags", {c, v, n, z}, 4'b0000);
        rst_n = 1'b1;
        #1;
        check("release in_ready", in_ready, 1);
        for (int i = 0; i < 17; i++) begin
            step();
            check("no ghost result", out_valid, 0);
        end
        issue(3'b000, 16'h0002, 16'h0003);
        step();
        in_valid = 1'b0;
        check("final add valid", out_valid, 1);
        check("final add result", result, 16'h0005);
        check("final add flags", {c, v, n, z}, 4'b0000);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
